// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID / build-info register block:
// register addresses, CTRL/CAPS bit positions and the uptime type.
package sysid_pkg;

    localparam logic [3:0] ADDR_SYS_ID    = 4'd0;
    localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
    localparam logic [3:0] ADDR_CAPS      = 4'd2;
    localparam logic [3:0] ADDR_CTRL      = 4'd3;
    localparam logic [3:0] ADDR_UPTIME_LO = 4'd4;
    localparam logic [3:0] ADDR_UPTIME_HI = 4'd5;
    localparam logic [3:0] ADDR_SCRATCH0  = 4'd8;

    localparam int CTRL_RUN_BIT   = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    localparam int CAPS_NSCR_LSB   = 0;
    localparam int CAPS_NSCR_W     = 4;
    localparam int CAPS_UPTIME_BIT = 4;
    localparam int CAPS_PRE_LSB    = 16;
    localparam int CAPS_PRE_W      = 16;

    typedef logic [63:0] uptime_t;

endpackage

// File: rtl/sysid_uptime_ctr.sv
// Prescaled 64-bit uptime counter: one tick every PRESCALE cycles while run=1.
// clear zeroes both prescaler and count and wins over a coincident tick.
module sysid_uptime_ctr
    import sysid_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic    clock,
    input  logic    reset_n,
    input  logic    run,
    input  logic    clear,
    output uptime_t count
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q;
    uptime_t       cnt_q;
    logic          tick;

    assign tick  = run && (pre_q == PW'(PRESCALE - 1));
    assign count = cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (run) begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (tick)
                cnt_q <= cnt_q + 64'd1;
        end
    end

endmodule

// File: rtl/sysid_info_regs.sv
// System-ID / build-info register block with scratch words and an optional
// free-running uptime counter (enabled by defining SYSID_UPTIME_EN).
module sysid_info_regs
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYS_ID      = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
    parameter int          NUM_SCRATCH = 2,
    parameter int          PRESCALE    = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

`ifdef SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
`else
    localparam logic UPTIME_PRESENT = 1'b0;
`endif

    logic [NUM_SCRATCH-1:0][31:0] scratch_q;
    logic [3:0]                   scr_idx;
    logic                         scr_hit;
    logic [31:0]                  caps;
    logic [31:0]                  rd_mux;

    assign scr_idx = address - ADDR_SCRATCH0;
    assign scr_hit = (address >= ADDR_SCRATCH0) && (scr_idx < 4'(NUM_SCRATCH));

    always_comb begin
        caps = '0;
        caps[CAPS_NSCR_LSB +: CAPS_NSCR_W] = CAPS_NSCR_W'(NUM_SCRATCH);
        caps[CAPS_UPTIME_BIT]              = UPTIME_PRESENT;
        caps[CAPS_PRE_LSB +: CAPS_PRE_W]   = CAPS_PRE_W'(PRESCALE - 1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q <= '0;
        end else if (write && scr_hit) begin
            for (int i = 0; i < NUM_SCRATCH; i++)
                if (scr_idx == 4'(i))
                    scratch_q[i] <= writedata;
        end
    end

`ifdef SYSID_UPTIME_EN
    logic        run_q;
    logic        ctrl_wr;
    logic        clear;
    logic [31:0] hi_snap_q;
    uptime_t     uptime;

    assign ctrl_wr = write && (address == ADDR_CTRL);
    assign clear   = ctrl_wr && writedata[CTRL_CLEAR_BIT];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            run_q <= 1'b0;
        else if (ctrl_wr)
            run_q <= writedata[CTRL_RUN_BIT];
    end

    // Reading LO freezes the high word so a LO-then-HI pair is coherent.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            hi_snap_q <= '0;
        else if (clear)
            hi_snap_q <= '0;
        else if (read && (address == ADDR_UPTIME_LO))
            hi_snap_q <= uptime[63:32];
    end

    sysid_uptime_ctr #(
        .PRESCALE (PRESCALE)
    ) u_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (run_q),
        .clear   (clear),
        .count   (uptime)
    );
`endif

    // Mux sees pre-write state, so a coincident read returns old data.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_SYS_ID:    rd_mux = SYS_ID;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_CAPS:      rd_mux = caps;
`ifdef SYSID_UPTIME_EN
            ADDR_CTRL:      rd_mux = {31'd0, run_q};
            ADDR_UPTIME_LO: rd_mux = uptime[31:0];
            ADDR_UPTIME_HI: rd_mux = hi_snap_q;
`endif
            default:        rd_mux = '0;
        endcase
        if (scr_hit)
            for (int i = 0; i < NUM_SCRATCH; i++)
                if (scr_idx == 4'(i))
                    rd_mux = scratch_q[i];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read)
                readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_sysid_info_regs.sv
// Randomized self-checking bench for sysid_info_regs against a cycle-count
// based reference model; uptime checks are built only with SYSID_UPTIME_EN.
module tb_sysid_info_regs;
    import sysid_pkg::*;

    localparam logic [31:0] P_SYS_ID = 32'h58C8_1A88;
    localparam logic [31:0] P_TS     = 32'h5BAD_BEEF;
    localparam int          P_NSCR   = 2;
    localparam int          P_PRE    = 4;
`ifdef SYSID_UPTIME_EN
    localparam bit UP = 1'b1;
`else
    localparam bit UP = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: uptime = m_base + (running cycles since clear) / PRESCALE
    logic [31:0]     m_scr [8];
    bit              m_run;
    longint unsigned m_cyc;
    longint unsigned m_base;
    logic [31:0]     m_snap;
    logic [31:0]     last_rd;

    sysid_info_regs #(
        .SYS_ID      (P_SYS_ID),
        .TIMESTAMP   (P_TS),
        .NUM_SCRATCH (P_NSCR),
        .PRESCALE    (P_PRE)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock)
        if (m_run) m_cyc = m_cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_uptime();
        return m_base + m_cyc / 64'(P_PRE);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        logic [63:0] up;
        int          idx;
        up  = m_uptime();
        idx = int'(a) - 8;
        if (a == 4'd0) return P_SYS_ID;
        if (a == 4'd1) return P_TS;
        if (a == 4'd2) return 32'(P_NSCR) | (32'(UP) << 4) | (32'(P_PRE - 1) << 16);
        if (UP && a == 4'd3) return {31'd0, m_run};
        if (UP && a == 4'd4) return up[31:0];
        if (UP && a == 4'd5) return m_snap;
        if (idx >= 0 && idx < P_NSCR) return m_scr[idx];
        return 32'd0;
    endfunction

    function automatic void m_reset();
        m_run  = 1'b0;
        m_cyc  = 0;
        m_base = 0;
        m_snap = '0;
        last_rd = '0;
        for (int i = 0; i < 8; i++) m_scr[i] = '0;
    endfunction

    // One bus cycle issued just after a rising edge; checks the response one edge later.
    task automatic bus_cycle(input logic rd, input logic wr, input logic [3:0] a, input logic [31:0] wd);
        logic [31:0] exp;
        logic [63:0] up;
        bit          do_snap;
        up      = m_uptime();
        exp     = rd ? exp_rd(a) : last_rd;
        do_snap = rd && UP && (a == 4'd4);
        read = rd; write = wr; address = a; writedata = wd;
        @(posedge clock); #1;
        read = 1'b0; write = 1'b0;
        if (do_snap) m_snap = up[63:32];
        if (wr) begin
            if (int'(a) >= 8 && int'(a) - 8 < P_NSCR) m_scr[int'(a) - 8] = wd;
            if (UP && a == 4'd3) begin
                m_run = wd[0];
                if (wd[1]) begin m_cyc = 0; m_base = 0; m_snap = '0; end
            end
        end
        chk($sformatf("rdv@%0d", a), {63'd0, readdatavalid}, {63'd0, rd});
        chk($sformatf("rdata@%0d", a), {32'd0, readdata}, {32'd0, exp});
        if (rd) last_rd = exp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic reset_mid_read();
        read = 1'b1; write = 1'b0; address = ADDR_UPTIME_LO;
        #2;
        reset_n = 1'b0;
        m_reset();
        #1;
        chk("rst_rdv_async", {63'd0, readdatavalid}, 64'd0);
        chk("rst_rdata_async", {32'd0, readdata}, 64'd0);
`ifdef SYSID_UPTIME_EN
        chk("rst_uptime_async", dut.uptime, 64'd0);
`endif
        @(posedge clock); #1;
        chk("rst_rdv_held", {63'd0, readdatavalid}, 64'd0);
        read = 1'b0;
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        chk("rst_rdv_after", {63'd0, readdatavalid}, 64'd0);
    endtask

    initial begin
        logic [3:0]  a;
        logic [31:0] wd;
        int          op;
        reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        m_reset();
        #12;
        chk("reset_rdv", {63'd0, readdatavalid}, 64'd0);
        chk("reset_rdata", {32'd0, readdata}, 64'd0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;

        // identity words and capabilities
        bus_cycle(1'b1, 1'b0, 4'd0, 32'd0);
        bus_cycle(1'b1, 1'b0, 4'd1, 32'd0);
        bus_cycle(1'b1, 1'b0, 4'd2, 32'd0);
        idle(2);
        // scratch and RO protection
        bus_cycle(1'b0, 1'b1, 4'd8, 32'hDEAD_0001);
        bus_cycle(1'b0, 1'b1, 4'd9, 32'hDEAD_0002);
        bus_cycle(1'b1, 1'b0, 4'd8, 32'd0);
        bus_cycle(1'b1, 1'b0, 4'd9, 32'd0);
        bus_cycle(1'b1, 1'b0, 4'd10, 32'd0);
        bus_cycle(1'b0, 1'b1, 4'd0, 32'h1234_5678);
        bus_cycle(1'b1, 1'b0, 4'd0, 32'd0);
        bus_cycle(1'b1, 1'b1, 4'd8, 32'hCAFE_F00D);
        bus_cycle(1'b1, 1'b0, 4'd8, 32'd0);
        // uptime block absent or idle: addresses 3-5
        bus_cycle(1'b0, 1'b1, 4'd3, 32'h0000_0000);
        bus_cycle(1'b1, 1'b0, 4'd3, 32'd0);
        bus_cycle(1'b1, 1'b0, 4'd4, 32'd0);
        bus_cycle(1'b1, 1'b0, 4'd5, 32'd0);

`ifdef SYSID_UPTIME_EN
        // run 40 cycles, then stop and confirm the count holds
        bus_cycle(1'b0, 1'b1, ADDR_CTRL, 32'h1);
        idle(40);
        bus_cycle(1'b1, 1'b0, ADDR_UPTIME_LO, 32'd0);
        bus_cycle(1'b0, 1'b1, ADDR_CTRL, 32'h0);
        idle(20);
        bus_cycle(1'b1, 1'b0, ADDR_UPTIME_LO, 32'd0);
        // clear coincident with a terminal-count tick
        bus_cycle(1'b0, 1'b1, ADDR_CTRL, 32'h3);
        idle(3);
        bus_cycle(1'b0, 1'b1, ADDR_CTRL, 32'h3);
        bus_cycle(1'b1, 1'b0, ADDR_UPTIME_LO, 32'd0);
        bus_cycle(1'b1, 1'b0, ADDR_CTRL, 32'd0);
        // 32-bit carry and HI snapshot coherence
        bus_cycle(1'b0, 1'b1, ADDR_CTRL, 32'h2);
        force dut.u_ctr.cnt_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.u_ctr.cnt_q;
        m_base = 64'h0000_0000_FFFF_FFFF;
        bus_cycle(1'b1, 1'b0, ADDR_UPTIME_LO, 32'd0);
        bus_cycle(1'b0, 1'b1, ADDR_CTRL, 32'h1);
        idle(5);
        bus_cycle(1'b1, 1'b0, ADDR_UPTIME_HI, 32'd0);
        bus_cycle(1'b1, 1'b0, ADDR_UPTIME_LO, 32'd0);
        bus_cycle(1'b1, 1'b0, ADDR_UPTIME_HI, 32'd0);
`endif

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 9));
            a  = 4'($urandom_range(0, 15));
            wd = $urandom;
            if (op <= 3)      bus_cycle(1'b1, 1'b0, a, wd);
            else if (op <= 5) bus_cycle(1'b0, 1'b1, a, wd);
            else if (op == 6) bus_cycle(1'b1, 1'b1, a, wd);
            else              idle(int'($urandom_range(1, 6)));
        end

        // asynchronous reset in the middle of a read with the counter running
        bus_cycle(1'b0, 1'b1, 4'd8, 32'hA5A5_0008);
        bus_cycle(1'b0, 1'b1, ADDR_CTRL, 32'h1);
        idle(9);
        reset_mid_read();
        bus_cycle(1'b1, 1'b0, 4'd8, 32'd0);
        bus_cycle(1'b1, 1'b0, 4'd9, 32'd0);
        bus_cycle(1'b1, 1'b0, 4'd3, 32'd0);
        bus_cycle(1'b1, 1'b0, 4'd4, 32'd0);
        bus_cycle(1'b1, 1'b0, 4'd2, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sysid_info_regs.md
SYSID_INFO_REGS -- requirements
Module: sysid_info_regs

Interface
REQ-001 SHALL provide parameter SYS_ID, default 32'h0000_0000, system identifier returned at word 0.
REQ-002 SHALL provide parameter TIMESTAMP, default 32'h0000_0000, build timestamp returned at word 1.
REQ-003 SHALL provide parameter NUM_SCRATCH, default 2, range 1..8, number of read/write scratch words.
REQ-004 SHALL provide parameter PRESCALE, default 1, range 1..65535, clock cycles per uptime tick.
REQ-005 SHALL have ports: clock in 1, single system clock; reset_n in 1, asynchronous active-low reset; address in 4, word address; read in 1, read strobe; write in 1, write strobe; writedata in 32, write data; readdata out 32, registered read data; readdatavalid out 1, read-data qualifier.

Function
REQ-006 Register map SHALL be: 0 SYS_ID (RO); 1 TIMESTAMP (RO); 2 CAPS (RO: [3:0]=NUM_SCRATCH, [4]=uptime present, [31:16]=PRESCALE-1 truncated to 16 bits); 3 CTRL (RW: [0]=RUN, [1]=CLEAR write-1 self-clearing, reads 0); 4 UPTIME_LO (RO); 5 UPTIME_HI (RO, snapshot); 6-7 reserved (read 0); 8..8+NUM_SCRATCH-1 SCRATCH (RW); all other addresses read 0.
REQ-007 Read latency SHALL be exactly 1: read asserted in cycle N -> readdata valid and readdatavalid=1 in cycle N+1; readdatavalid=0 otherwise.
REQ-008 readdata SHALL hold its last value when readdatavalid=0.
REQ-009 Writes SHALL take effect on the clock edge on which write is sampled; writes to RO/reserved addresses SHALL be ignored.
REQ-010 read and write asserted together SHALL perform the write and return pre-write data for the read.
REQ-011 Prescaler SHALL count 0..PRESCALE-1 while RUN=1, emitting one tick at terminal count and wrapping to 0; with RUN=0 prescaler and uptime SHALL hold.
REQ-012 Uptime SHALL be a 64-bit counter incremented by 1 per tick, wrapping from 2^64-1 to 0.
REQ-013 Writing CLEAR=1 SHALL zero uptime, prescaler and HI snapshot on that edge; clear SHALL take priority over a coincident tick.
REQ-014 Reading UPTIME_LO SHALL return the current low word and simultaneously latch the current high word into the HI snapshot register, so a LO-then-HI read pair is atomic.
REQ-015 Reading UPTIME_HI SHALL return the snapshot, not the live high word.
REQ-016 Writing CTRL with RUN and CLEAR both 1 SHALL clear and then count from 0 on the next tick.

Reset
REQ-017 While reset_n=0: readdata=0, readdatavalid=0, RUN=0, uptime=0, prescaler=0, HI snapshot=0, all SCRATCH=0.
REQ-018 Reset deassertion mid-transaction SHALL not produce a readdatavalid for a read issued during reset.
REQ-019 Reset SHALL take effect asynchronously, independent of clock.

Configuration
REQ-020 Macro SYSID_UPTIME_EN defined: prescaler, uptime counter, snapshot and CTRL implemented; CAPS[4]=1.
REQ-021 Macro SYSID_UPTIME_EN undefined: no prescaler/counter logic; addresses 3-5 read 0, writes ignored; CAPS[4]=0; all other behaviour unchanged.

Structure
REQ-022 Shared package sysid_pkg SHALL hold register address constants, CTRL/CAPS bit-index constants and the 64-bit uptime type.
REQ-023 Prescaler+uptime counter SHALL be one sub-module sysid_uptime_ctr (inputs run, clear; outputs 64-bit count); no other sub-modules.

Verification
REQ-024 SYS_ID=32'h58C8_1A88, TIMESTAMP=32'h5BAD_BEEF: read addr 0 then 1 -> 32'h58C8_1A88, 32'h5BAD_BEEF, each one cycle after read with readdatavalid=1.
REQ-025 NUM_SCRATCH=2: write 32'hDEAD_0001 to 8, 32'hDEAD_0002 to 9, read 8,9,10 -> 32'hDEAD_0001, 32'hDEAD_0002, 0; write to addr 0 then read -> SYS_ID unchanged.
REQ-026 PRESCALE=4: write CTRL=1, wait 40 cycles, read LO -> 10 (±1 for access alignment); write CTRL=0, wait 20 cycles, read LO -> unchanged.
REQ-027 Force uptime to 64'h0000_0000_FFFF_FFFF, read LO (returns FFFF_FFFF), let one tick elapse, read HI -> 0 (snapshot), then read LO/HI -> 0000_0000/0000_0001.
REQ-028 CLEAR write coincident with terminal tick -> uptime=0 next cycle; CTRL readback bit1=0.
REQ-029 Assert reset_n=0 mid-read with counter running -> readdatavalid=0, uptime=0, SCRATCH=0 immediately; build without SYSID_UPTIME_EN -> CAPS[4]=0, addr 4 reads 0.
